// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the slice-serial adder controller: FSM encoding,
// slice width and index sizing.
package adder_ctrl_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Slice index register width; a single slice still needs one bit.
  function automatic int idx_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/adder2_cin.sv
// Combinational 2-bit adder slice with carry-in, shared across all passes.
module adder2_cin
  import adder_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequences one 2-bit adder slice over WIDTH-bit operands, LSB slice first,
// with valid/ready handshakes on both the operand and result sides.
module adder_seq_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int SLICES = WIDTH / SLICE_W;
  localparam int IDX_W  = idx_width(SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("adder_seq_ctrl: WIDTH must be even and >= 2");
  end

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               accept;
  logic               last;

  assign accept = in_valid && in_ready;
  assign last   = (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid) state_next = ST_RUN;
      ST_RUN:  if (last)     state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Operand capture; only consumed in RUN, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= in_a;
      b_reg <= in_b;
    end
  end

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < SLICES; i++) begin
      if (idx == IDX_W'(i)) begin
        slice_a = a_reg[i*SLICE_W +: SLICE_W];
        slice_b = b_reg[i*SLICE_W +: SLICE_W];
      end
    end
  end

  adder2_cin u_slice (
    .a         (slice_a),
    .b         (slice_b),
    .cin       (carry),
    .sum       (slice_sum),
    .carry_out (slice_cout)
  );

  // Slice sequencing: carry chains through the register between passes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            carry <= in_cin;
            idx   <= '0;
          end
        end
        ST_RUN: begin
          carry <= slice_cout;
          for (int i = 0; i < SLICES; i++) begin
            if (idx == IDX_W'(i)) out_sum[i*SLICE_W +: SLICE_W] <= slice_sum;
          end
          if (last) out_cout <= slice_cout;
          else      idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked each cycle against a transaction-level model.
module tb_adder_seq_ctrl;

  localparam int WIDTH  = 8;
  localparam int SLICES = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  int total = 0;
  int bad   = 0;

  adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level reference: an accepted pair is busy for SLICES cycles,
  // then the arithmetic sum is presented until the consumer takes it.
  bit               m_pend;
  bit               m_have;
  int               m_cnt;
  logic [WIDTH-1:0] m_a, m_b;
  logic             m_cin;
  logic [WIDTH-1:0] m_sum;
  logic             m_cout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_have = 0; m_cnt = 0;
      m_sum  = '0; m_cout = 1'b0;
    end else if (m_have) begin
      if (out_ready) m_have = 0;
    end else if (m_pend) begin
      m_cnt--;
      if (m_cnt == 0) begin
        logic [WIDTH:0] full;
        full   = {1'b0, m_a} + {1'b0, m_b} + (WIDTH+1)'(m_cin);
        m_sum  = full[WIDTH-1:0];
        m_cout = full[WIDTH];
        m_pend = 0;
        m_have = 1;
      end
    end else if (in_valid) begin
      m_pend = 1; m_cnt = SLICES;
      m_a = in_a; m_b = in_b; m_cin = in_cin;
    end
  end

  // Per-cycle compare plus a log of accepts and delivered results.
  int               cyc = 0;
  int               busy_cnt = 0;
  int               acc_q[$];
  int               res_cyc[$];
  logic [WIDTH-1:0] res_sum[$];
  logic             res_cout[$];

  always @(negedge clk) begin
    cyc++;
    check("in_ready", 32'(in_ready), 32'(!m_pend && !m_have));
    check("out_valid", 32'(out_valid), 32'(m_have));
    check("busy", 32'(busy), 32'(m_pend || m_have));
    if (m_have || !m_pend) begin
      check("out_sum", 32'(out_sum), 32'(m_sum));
      check("out_cout", 32'(out_cout), 32'(m_cout));
    end
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && out_ready) begin
        res_cyc.push_back(cyc);
        res_sum.push_back(out_sum);
        res_cout.push_back(out_cout);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    acc_q.delete(); res_cyc.delete(); res_sum.delete(); res_cout.delete();
    busy_cnt = 0;
  endtask

  // Offer operands and return just after the accepting edge; in_valid stays high.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    int n;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(in_ready), 32'd1);
    tick();
  endtask

  task automatic wait_results(input int count);
    int n;
    n = 0;
    while (res_sum.size() < count && n < 100) begin
      tick();
      n++;
    end
    if (res_sum.size() < count) check("result_timeout", 32'(res_sum.size()), 32'(count));
  endtask

  task automatic expect_res(input int k, input logic [WIDTH-1:0] s, input logic c);
    if (res_sum.size() > k) begin
      check($sformatf("res%0d_sum", k), 32'(res_sum[k]), 32'(s));
      check($sformatf("res%0d_cout", k), 32'(res_cout[k]), 32'(c));
    end else begin
      check($sformatf("res%0d_missing", k), 32'(res_sum.size()), 32'(k + 1));
    end
  endtask

  logic [WIDTH-1:0] st_a [3] = '{8'h80, 8'h7F, 8'h00};
  logic [WIDTH-1:0] st_b [3] = '{8'h80, 8'h01, 8'h00};
  logic             st_c [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic add with consumer always ready.
    clear_log();
    out_ready = 1'b1;
    send(8'h5A, 8'h3C, 1'b0);
    in_valid = 1'b0;
    wait_results(1);
    repeat (3) tick();
    expect_res(0, 8'h96, 1'b0);
    // valid is first observed on the falling edge after edge T+SLICES
    if (acc_q.size() > 0 && res_cyc.size() > 0)
      check("latency", 32'(res_cyc[0] - acc_q[0]), 32'(SLICES + 1));
    check("busy_cycles", 32'(busy_cnt), 32'd5);

    // Full carry ripple.
    clear_log();
    send(8'hFF, 8'h01, 1'b0);
    send(8'hFF, 8'h00, 1'b1);
    in_valid = 1'b0;
    wait_results(2);
    expect_res(0, 8'h00, 1'b1);
    expect_res(1, 8'h00, 1'b1);

    // Backpressure with a new operand pair waiting.
    clear_log();
    out_ready = 1'b0;
    send(8'h5A, 8'h3C, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("bp_valid", 32'(out_valid), 32'd1);
    in_a = 8'h11; in_b = 8'h22; in_cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_sum", 32'(out_sum), 32'h96);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    check("bp_no_accept", 32'(acc_q.size()), 32'd1);
    out_ready = 1'b1;
    send(8'h11, 8'h22, 1'b0);
    in_valid = 1'b0;
    wait_results(2);
    expect_res(0, 8'h96, 1'b0);
    expect_res(1, 8'h33, 1'b0);

    // Asynchronous reset in the middle of RUN.
    send(8'hAA, 8'h55, 1'b0);
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_sum", 32'(out_sum), 32'd0);
    check("abort_out_cout", 32'(out_cout), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    clear_log();
    repeat (8) tick();
    check("abort_no_result", 32'(res_sum.size()), 32'd0);
    send(8'h01, 8'h01, 1'b0);
    in_valid = 1'b0;
    wait_results(1);
    expect_res(0, 8'h02, 1'b0);

    // Back-to-back streaming with both handshakes held high.
    repeat (2) tick();
    clear_log();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_a = st_a[k]; in_b = st_b[k]; in_cin = st_c[k];
      n = 0;
      while (acc_q.size() < k + 1 && n < 50) begin tick(); n++; end
    end
    in_valid = 1'b0;
    wait_results(3);
    expect_res(0, 8'h00, 1'b1);
    expect_res(1, 8'h80, 1'b0);
    expect_res(2, 8'h01, 1'b0);
    if (acc_q.size() >= 3) begin
      check("stream_period0", 32'(acc_q[1] - acc_q[0]), 32'd6);
      check("stream_period1", 32'(acc_q[2] - acc_q[1]), 32'd6);
    end else begin
      check("stream_accepts", 32'(acc_q.size()), 32'd3);
    end

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a      = WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
      in_cin    = 1'($urandom);
      if (i == 300) rst_n = 1'b0;
      if (i == 302) rst_n = 1'b1;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Multi-cycle controller that sequences one shared 2-bit adder slice (with carry-in) to add two WIDTH-bit operands, least-significant slice first.
- Carry propagates through a carry register between cycles.
- Operands enter through a valid/ready input handshake. The result leaves through a valid/ready output handshake.
- Sits between an operand producer and a result consumer. It trades latency for minimal adder hardware.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be even and >= 2.
- SLICES, WIDTH/2, number of adder passes. Derived; not overridden.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  producer offers in_a/in_b/in_cin.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry into slice 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_sum  output  WIDTH  sum modulo 2^WIDTH.
- out_cout  output  1  carry out of the top slice.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, carry=0, out_sum=0, out_cout=0, out_valid=0, busy=0, in_ready=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_a, in_b, carry<=in_cin, idx<=0, state->RUN.
  - in_valid low: stay in IDLE.
- RUN:
  - in_ready=0. in_valid is ignored and operands are not sampled.
  - Each cycle, slice computes {c,s} = a[2*idx+1:2*idx] + b[2*idx+1:2*idx] + carry, using a 3-bit internal result with no truncation.
  - s is written into the sum register at bits [2*idx+1:2*idx]. carry<=c.
  - If idx==SLICES-1: out_cout<=c, state->DONE. Otherwise idx<=idx+1.
- DONE:
  - out_valid=1. out_sum and out_cout are held stable while out_ready is low.
  - On out_ready: state->IDLE, out_valid falls next cycle.
  - out_sum/out_cout keep their last value until the next result completes.
- Latency: accept at edge T -> out_valid high after edge T+SLICES (4 cycles at WIDTH=8). The minimum accept-to-accept period is SLICES+2 cycles.
- out_sum bits of slices not yet computed in RUN are don't-care. They are only valid when out_valid=1.
- Overflow: the result wraps modulo 2^WIDTH. out_cout=1 iff a+b+cin >= 2^WIDTH.
- Boundary cases:
  - WIDTH=2: one RUN cycle.
  - idx wraps only through the IDLE re-init, never by counter overflow.
  - out_ready high while not in DONE has no effect.
- Reset mid-operation: an asynchronous drop in RUN or DONE aborts immediately to reset values. The partial result is discarded and no out_valid pulse occurs.
- Width of idx: clog2(SLICES), minimum 1 bit.

Decomposition:
- Shared package adder_ctrl_pkg holds:
  - the state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2),
  - SLICE_W=2.
- Sub-module adder2_cin: combinational 2-bit adder.
  - Inputs: a[1:0], b[1:0], cin.
  - Outputs: sum[1:0], carry_out.
  - Implemented as {carry_out,sum}=a+b+cin.
  - Instantiated once and driven by the controller's slice mux.

Test Plan (WIDTH=8):
- 0x5A+0x3C, cin=0, out_ready=1 -> out_valid 4 cycles after accept, out_sum=0x96, out_cout=0, busy high for 5 cycles.
- 0xFF+0x01, cin=0 -> out_sum=0x00, out_cout=1 (carry ripples through all 4 passes). 0xFF+0x00, cin=1 -> out_sum=0x00, out_cout=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid with in_valid=1 and new operands 0x11/0x22 -> out_sum stays 0x96, in_ready=0, new operands not taken until after the out_ready handshake; they then produce 0x33.
- Reset mid-RUN: drop rst_n 2 cycles after accepting 0xAA+0x55 -> all outputs reset at once, in_ready=1 and no out_valid after release. A fresh 0x01+0x01 then yields 0x02, cout=0.
- Back-to-back streaming: in_valid and out_ready held high with 0x80+0x80, 0x7F+0x01, 0x00+0x00 cin=1 -> results (0x00,1), (0x80,0), (0x01,0) in order, one every 6 cycles.
